// File: rtl/mdu_alu_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation codes,
// ALU Card encodings (common with the ALU decoder) and sequencer states.
package mdu_pkg;

    // Operation select presented by the EX stage
    typedef enum logic [1:0] {
        OP_MUL   = 2'd0,
        OP_MULHU = 2'd1,
        OP_DIVU  = 2'd2,
        OP_REMU  = 2'd3
    } op_t;

    // ALU Card values; CARD_NONE forces the ALU output to zero
    localparam logic [4:0] CARD_NONE = 5'b00000;
    localparam logic [4:0] CARD_ADD  = 5'b00001;
    localparam logic [4:0] CARD_SUB  = 5'b00011;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_STEP = 2'd1,
        DIV_STEP = 2'd2,
        DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/mdu_alu_seq_if.sv
// Request/response bundle between the EX stage (master) and the
// multiply/divide sequencer (slave).
interface mdu_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, rs1, rs2,
        input  busy, done, result
    );

    modport slave (
        input  start, op, rs1, rs2,
        output busy, done, result
    );
endinterface

// File: rtl/mdu_alu_seq.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer. It owns no adder:
// every iteration drives the shared 32-bit ALU (A, B, Card) and folds the
// returned F/Cout back into its shift registers. The multiply (hi/lo/mcand)
// and divide (rem/quo/dvs) register sets are never live at the same time,
// so they share one set of physical registers: acc (hi/rem), shf (lo/quo)
// and opb (mcand/dvs).
module mdu_alu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int STEPS = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    mdu_if.slave            bus,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [4:0]      alu_card,
    input  logic [XLEN-1:0] alu_f,
    input  logic            alu_cout
);

    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

    state_t            state_reg,  state_next;
    op_t               op_reg,     op_next;
    logic [XLEN-1:0]   acc_reg,    acc_next;     // hi (MUL) / rem (DIV)
    logic [XLEN-1:0]   shf_reg,    shf_next;     // lo (MUL) / quo (DIV)
    logic [XLEN-1:0]   opb_reg,    opb_next;     // mcand (MUL) / dvs (DIV)
    logic [CNT_W-1:0]  cnt_reg,    cnt_next;
    logic [XLEN-1:0]   result_reg, result_next;

    logic [XLEN:0]     sh;   // divide partial remainder shifted left by one
    logic              ge;   // shifted remainder >= divisor

    // State, counter and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            op_reg     <= OP_MUL;
            acc_reg    <= '0;
            shf_reg    <= '0;
            opb_reg    <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            acc_reg    <= acc_next;
            shf_reg    <= shf_next;
            opb_reg    <= opb_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
        end
    end

    // Next-state, datapath update and ALU drive for each sequencer state
    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        acc_next    = acc_reg;
        shf_next    = shf_reg;
        opb_next    = opb_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        alu_a       = '0;
        alu_b       = '0;
        alu_card    = CARD_NONE;
        sh          = '0;
        ge          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    op_next  = op_t'(bus.op);
                    acc_next = '0;
                    shf_next = bus.rs1;
                    opb_next = bus.rs2;
                    cnt_next = CNT_LAST;
                    if (bus.op[1] && (bus.rs2 == '0)) begin
                        // Divide by zero: RISC-V defined results, no iterations
                        state_next  = DONE;
                        result_next = (op_t'(bus.op) == OP_DIVU) ? '1 : bus.rs1;
                    end else if (!bus.op[1]) begin
                        state_next = MUL_STEP;
                    end else begin
                        state_next = DIV_STEP;
                    end
                end
            end

            MUL_STEP: begin
                // Shift-add: add multiplicand to hi when the current lo bit is set
                alu_card = CARD_ADD;
                alu_a    = acc_reg;
                alu_b    = shf_reg[0] ? opb_reg : '0;
                acc_next = {alu_cout, alu_f[XLEN-1:1]};
                shf_next = {alu_f[0], shf_reg[XLEN-1:1]};
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == '0) begin
                    state_next  = DONE;
                    result_next = (op_reg == OP_MULHU) ? acc_next : shf_next;
                end
            end

            DIV_STEP: begin
                // Restoring division; Cout=1 from A-B means no borrow. A set
                // sh[XLEN] already implies sh > dvs since dvs fits in XLEN bits.
                sh       = {acc_reg, shf_reg[XLEN-1]};
                alu_card = CARD_SUB;
                alu_a    = sh[XLEN-1:0];
                alu_b    = opb_reg;
                ge       = sh[XLEN] | alu_cout;
                acc_next = ge ? alu_f : sh[XLEN-1:0];
                shf_next = {shf_reg[XLEN-2:0], ge};
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == '0) begin
                    state_next  = DONE;
                    result_next = (op_reg == OP_REMU) ? acc_next : shf_next;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy   = (state_reg == MUL_STEP) || (state_reg == DIV_STEP);
    assign bus.done   = (state_reg == DONE);
    assign bus.result = result_reg;

endmodule

// File: tb/tb_mdu_alu_seq.sv
// Self-checking bench for mdu_alu_seq: a behavioural ALU closes the loop,
// directed requests push expected results into a scoreboard and a monitor
// pops and compares whenever done is presented.
module tb_mdu_alu_seq;
    import mdu_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdu_if #(.XLEN(XLEN)) bus ();

    logic [XLEN-1:0] alu_a, alu_b, alu_f;
    logic [4:0]      alu_card;
    logic            alu_cout;
    logic [XLEN:0]   alu_sum;

    mdu_alu_seq #(.XLEN(XLEN), .STEPS(XLEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_card (alu_card),
        .alu_f    (alu_f),
        .alu_cout (alu_cout)
    );

    // ALU with Cin tied to 0: ADD = A+B, SUB = A+~B+1 (Cout=1 means no borrow)
    always_comb begin
        alu_sum = '0;
        case (alu_card)
            CARD_ADD: alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
            CARD_SUB: alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {{XLEN{1'b0}}, 1'b1};
            default:  alu_sum = '0;
        endcase
    end
    assign alu_f    = alu_sum[XLEN-1:0];
    assign alu_cout = alu_sum[XLEN];

    typedef struct {
        string           name;
        logic [XLEN-1:0] exp;
        int              lat;
        int              drive_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every done must match the oldest outstanding request
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: result=%h with no request outstanding", bus.result);
            end else begin
                mon_e = sb.pop_front();
                if (bus.result !== mon_e.exp) begin
                    errors++;
                    $display("FAIL %s result: got %h, want %h", mon_e.name, bus.result, mon_e.exp);
                end else begin
                    $display("ok   %s result=%h latency=%0d", mon_e.name, bus.result, cyc - mon_e.drive_cyc);
                end
                checks++;
                if (cyc - mon_e.drive_cyc != mon_e.lat) begin
                    errors++;
                    $display("FAIL %s latency: got %0d, want %0d", mon_e.name, cyc - mon_e.drive_cyc, mon_e.lat);
                end
            end
        end
    end

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Drive one request; start is sampled at the following edge
    task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] exp, input int lat, input string name, input bit hold);
        exp_t e;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs1   = a;
        bus.rs2   = b;
        e.name = name;
        e.exp  = exp;
        e.lat  = lat;
        e.drive_cyc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
    endtask

    // Wait (bounded) for done, recording busy behaviour along the way
    task automatic wait_done(input string name, input int bound, output logic first_busy, output logic any_busy);
        bit seen;
        seen = 1'b0;
        first_busy = 1'b0;
        any_busy = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (i == 0) first_busy = bus.busy;
            if (bus.busy) any_busy = 1'b1;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: done not seen within %0d cycles", name, bound);
        end
    endtask

    task automatic run(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] exp, input int lat, input string name);
        logic fb, ab;
        issue(op, a, b, exp, lat, name, 1'b0);
        wait_done(name, lat + 5, fb, ab);
        if (lat > 1) begin
            check({name, " busy_next_cycle"}, {31'd0, fb}, 32'd1);
        end else begin
            check({name, " busy_never"}, {31'd0, ab}, 32'd0);
        end
        @(negedge clk);
        check({name, " card_after_done"}, {27'd0, alu_card}, {27'd0, CARD_NONE});
        check({name, " done_one_cycle"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic fb, ab;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.rs1   = '0;
        bus.rs2   = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy",   {31'd0, bus.busy}, 32'd0);
        check("reset done",   {31'd0, bus.done}, 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset card",   {27'd0, alu_card}, 32'd0);
        check("reset alu_a",  alu_a, 32'd0);
        check("reset alu_b",  alu_b, 32'd0);
        rst = 1'b0;

        run(2'd0, 32'd7,        32'd6,        32'h0000002A, 33, "mul_7x6");
        run(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu_max");
        run(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33, "mul_max");
        run(2'd0, 32'h12345678, 32'h00000010, 32'h23456780, 33, "mul_shift4");
        run(2'd1, 32'h12345678, 32'h00000010, 32'h00000001, 33, "mulhu_shift4");
        run(2'd2, 32'd100,      32'd7,        32'h0000000E, 33, "divu_100_7");
        run(2'd3, 32'd100,      32'd7,        32'h00000002, 33, "remu_100_7");
        run(2'd2, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33, "divu_max_1");
        run(2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, "remu_msb_max");
        run(2'd2, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  "divu_by_zero");
        run(2'd3, 32'd5,        32'd0,        32'h00000005, 1,  "remu_by_zero");

        // Start held high with operands changing while busy: only one operation
        issue(2'd0, 32'd3, 32'd3, 32'd9, 33, "mul_3x3_hold", 1'b1);
        bus.op  = 2'd1;
        bus.rs1 = 32'd5;
        bus.rs2 = 32'd5;
        wait_done("mul_3x3_hold", 38, fb, ab);
        bus.start = 1'b0;
        check("mul_3x3_hold busy_next_cycle", {31'd0, fb}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold no_second_op", {31'd0, bus.busy}, 32'd0);
        end
        check("hold result_held", bus.result, 32'd9);

        // Reset part-way through a multiply abandons it
        issue(2'd0, 32'd11, 32'd13, 32'd143, 33, "mul_abandoned", 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        void'(sb.pop_back());
        @(posedge clk);
        @(negedge clk);
        check("midreset busy",   {31'd0, bus.busy}, 32'd0);
        check("midreset done",   {31'd0, bus.done}, 32'd0);
        check("midreset result", bus.result, 32'd0);
        check("midreset card",   {27'd0, alu_card}, 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        run(2'd0, 32'd2, 32'd2, 32'd4, 33, "mul_2x2_after_reset");

        check("scoreboard drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
